// File: rtl/alu_issue_ctrl_if.sv
// Instruction handshake and ALU operand/opcode bus for alu_issue_ctrl.
// The controller is the initiator of the ALU bus, so it takes the master
// modport; the slave modport is the environment (front end plus ALU).
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic [8:0] instr;
  logic       instr_ready;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_op;
  logic [7:0] alu_result;

  modport master (
    input  instr_valid, instr, alu_result,
    output instr_ready, alu_a, alu_b, alu_op
  );

  modport slave (
    output instr_valid, instr, alu_result,
    input  instr_ready, alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-state issue/decode controller for an external 8-bit
// combinational ALU. Owns a 4x8 register file, decodes 9-bit C-type and
// S-type instructions, issues operands, captures the result and writes back.
// Optional feature macro: ALU_ISSUE_ZERO_FLAG_EN (adds the zero_flag output).
module alu_issue_ctrl #(
  parameter int NREG = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_ctrl_if.master        bus,
  input  logic                    load_en,
  input  logic [1:0]              load_addr,
  input  logic [7:0]              load_data,
  output logic                    done,
  output logic                    illegal,
  input  logic [1:0]              dbg_sel,
  output logic [7:0]              dbg_data
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  ,
  output logic                    zero_flag
`endif
);

  localparam logic [4:0] OP_NOT     = 5'b00010;
  localparam logic [4:0] OP_SHL     = 5'b10000;
  localparam logic [4:0] OP_SHR     = 5'b10001;
  localparam logic [4:0] OP_ILLEGAL = 5'b11111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [8:0] instr_q;
  logic [7:0] rf [NREG];
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [4:0] alu_op_q;
  logic [7:0] result_q;
  logic [4:0] dec_op;
  logic [7:0] dec_b;
  logic [1:0] rd;
  logic [1:0] rs;
  logic       accept;
  logic       wb_legal;

  assign rd       = instr_q[3:2];
  assign rs       = instr_q[1:0];
  assign accept   = bus.instr_valid && bus.instr_ready;
  assign wb_legal = (state == S_WB) && (alu_op_q != OP_ILLEGAL);

  assign bus.alu_a  = alu_a_q;
  assign bus.alu_b  = alu_b_q;
  assign bus.alu_op = alu_op_q;
  assign dbg_data   = rf[dbg_sel];

  // State register; reset aborts any instruction in flight.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed IDLE -> DECODE -> EXEC -> WB ring, gated by the handshake.
  // NOTE: every variable driven in always_comb gets a default on entry; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (accept) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Handshake and retire outputs; a direct load in IDLE blocks acceptance.
  always_comb begin
    bus.instr_ready = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    unique case (state)
      S_IDLE: bus.instr_ready = !load_en;
      S_WB: begin
        done    = 1'b1;
        illegal = (alu_op_q == OP_ILLEGAL);
      end
      default: ;
    endcase
  end

  // Instruction decode from the latched word into ALU opcode and operand b.
  always_comb begin
    dec_op = OP_ILLEGAL;
    dec_b  = rf[rs];
    if (instr_q[8]) begin
      dec_op = instr_q[7] ? OP_SHR : OP_SHL;
      dec_b  = {5'b0, instr_q[6:4]};
    end else begin
      unique case (instr_q[7:4])
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: dec_op = {1'b0, instr_q[7:4]};
        default:                            dec_op = OP_ILLEGAL;
      endcase
      if ({1'b0, instr_q[7:4]} == OP_NOT) dec_b = 8'h00;
    end
  end

  // Instruction word is sampled only at the handshake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instr_q <= '0;
    else if (accept) instr_q <= bus.instr;
  end

  // Operand/opcode issue registers, held from DECODE until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_q  <= 8'h00;
      alu_b_q  <= 8'h00;
      alu_op_q <= 5'b00000;
    end else if (state == S_DECODE) begin
      alu_a_q  <= rf[rd];
      alu_b_q  <= dec_b;
      alu_op_q <= dec_op;
    end
  end

  // ALU result capture during EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 result_q <= 8'h00;
    else if (state == S_EXEC)   result_q <= bus.alu_result;
  end

  // Register file: direct load in IDLE, legal writeback in WB.
  // NOTE: every entry is reset because the file must read 0x00 after reset;
  // that keeps it in flops, so no RAM macro can be inferred for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= 8'h00;
    end else if ((state == S_IDLE) && load_en) begin
      rf[load_addr] <= load_data;
    end else if (wb_legal) begin
      rf[rd] <= result_q;
    end
  end

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  // Zero flag tracks the last legal writeback only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        zero_flag <= 1'b0;
    else if (wb_legal) zero_flag <= (result_q == 8'h00);
  end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. Provides a behavioural ALU on the
// bus, a shadow register file, and a scoreboard of expected retirements.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_en;
  logic [1:0] load_addr;
  logic [7:0] load_data;
  logic       done;
  logic       illegal;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic       zero_flag;
  logic       sh_zf;
`endif

  alu_issue_ctrl_if bus ();

  alu_issue_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .done      (done),
    .illegal   (illegal),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    ,
    .zero_flag (zero_flag)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural combinational ALU.
  always_comb begin
    case (bus.alu_op)
      5'h00:   bus.alu_result = bus.alu_a & bus.alu_b;
      5'h01:   bus.alu_result = bus.alu_a | bus.alu_b;
      5'h02:   bus.alu_result = (bus.alu_a == 8'h00) ? 8'h01 : 8'h00;
      5'h03:   bus.alu_result = bus.alu_a ^ bus.alu_b;
      5'h04:   bus.alu_result = bus.alu_a + bus.alu_b;
      5'h05:   bus.alu_result = bus.alu_a - bus.alu_b;
      5'h10:   bus.alu_result = bus.alu_a << bus.alu_b[2:0];
      5'h11:   bus.alu_result = bus.alu_a >> bus.alu_b[2:0];
      default: bus.alu_result = 8'h00;
    endcase
  end

  typedef struct {
    logic [8:0] ins;
    logic [1:0] rd;
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       ill;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] sh_rf[4];
  int         n_cmp = 0;
  int         n_err = 0;

  // Expected issue/retire values for an instruction against the shadow file.
  function automatic exp_t model(input logic [8:0] ins);
    exp_t       e;
    logic [2:0] sh;
    e.ins = ins;
    e.rd  = ins[3:2];
    e.a   = sh_rf[ins[3:2]];
    e.ill = 1'b0;
    e.res = 8'h00;
    if (ins[8]) begin
      sh  = ins[6:4];
      e.b = {5'b0, sh};
      if (ins[7]) begin e.op = 5'h11; e.res = e.a >> sh; end
      else        begin e.op = 5'h10; e.res = e.a << sh; end
    end else begin
      e.b = sh_rf[ins[1:0]];
      case (ins[7:4])
        4'd0: begin e.op = 5'h00; e.res = e.a & e.b; end
        4'd1: begin e.op = 5'h01; e.res = e.a | e.b; end
        4'd2: begin e.op = 5'h02; e.b = 8'h00; e.res = (e.a == 8'h00) ? 8'h01 : 8'h00; end
        4'd3: begin e.op = 5'h03; e.res = e.a ^ e.b; end
        4'd4: begin e.op = 5'h04; e.res = e.a + e.b; end
        4'd5: begin e.op = 5'h05; e.res = e.a - e.b; end
        default: begin e.op = 5'h1f; e.ill = 1'b1; end
      endcase
    end
    return e;
  endfunction

  task automatic do_load(input logic [1:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = addr; load_data = data;
    @(posedge clk); #1;
    load_en = 1'b0;
    sh_rf[addr] = data;
  endtask

  // Offer an instruction, wait for retirement, and compare against the scoreboard.
  task automatic issue(input logic [8:0] ins, input bit synced, output int waited);
    exp_t e;
    bit   hs;
    int   lat;
    hs = 1'b0;
    waited = 0;
    lat = 0;
    if (!synced) begin @(posedge clk); #1; end
    bus.instr = ins;
    bus.instr_valid = 1'b1;
    for (int k = 0; k < 8 && !hs; k++) begin
      @(negedge clk);
      waited++;
      if (bus.instr_ready) begin @(posedge clk); hs = 1'b1; end
    end
    #1;
    bus.instr_valid = 1'b0;
    bus.instr = 9'($urandom);
    if (!hs) begin
      n_cmp++; n_err++;
      $display("FAIL handshake_timeout ins=%b: instr_ready never seen high", ins);
      return;
    end
    sb.push_back(model(ins));
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
    end
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL latency ins=%b: got %0d want 3", ins, lat); end
    e = sb.pop_front();
    if (lat == 0) return;
    n_cmp++;
    if (bus.alu_op !== e.op) begin n_err++; $display("FAIL alu_op ins=%b: got %b want %b", ins, bus.alu_op, e.op); end
    n_cmp++;
    if (bus.alu_a !== e.a) begin n_err++; $display("FAIL alu_a ins=%b: got %h want %h", ins, bus.alu_a, e.a); end
    n_cmp++;
    if (bus.alu_b !== e.b) begin n_err++; $display("FAIL alu_b ins=%b: got %h want %h", ins, bus.alu_b, e.b); end
    n_cmp++;
    if (illegal !== e.ill) begin n_err++; $display("FAIL illegal ins=%b: got %b want %b", ins, illegal, e.ill); end
    if (!e.ill) begin
      sh_rf[e.rd] = e.res;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
      sh_zf = (e.res == 8'h00);
`endif
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      n_err++; $display("FAIL pulse_width ins=%b: done=%b illegal=%b want 0 0", ins, done, illegal);
    end
    n_cmp++;
    if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_wb ins=%b: got %b want 1", ins, bus.instr_ready); end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++;
      if (dbg_data !== sh_rf[i]) begin n_err++; $display("FAIL rf%0d ins=%b: got %h want %h", i, ins, dbg_data, sh_rf[i]); end
    end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    n_cmp++;
    if (zero_flag !== sh_zf) begin n_err++; $display("FAIL zero_flag ins=%b: got %b want %b", ins, zero_flag, sh_zf); end
`endif
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_op !== 5'b00000) begin
      n_err++; $display("FAIL reset_alu_bus: a=%h b=%h op=%b want 00 00 00000", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    n_cmp++;
    if (done !== 1'b0 || illegal !== 1'b0) begin
      n_err++; $display("FAIL reset_pulses: done=%b illegal=%b want 0 0", done, illegal);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++;
      if (dbg_data !== 8'h00) begin n_err++; $display("FAIL reset_rf%0d: got %h want 00", i, dbg_data); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.instr_ready); end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    n_cmp++;
    if (zero_flag !== 1'b0) begin n_err++; $display("FAIL reset_zero_flag: got %b want 0", zero_flag); end
`endif
  endtask

  task automatic test_and;
    int w;
    do_load(2'd0, 8'h0F);
    do_load(2'd1, 8'hF0);
    issue(9'b0_0000_00_01, 1'b0, w);
    n_cmp++;
    if (bus.alu_op !== 5'b00000 || bus.alu_a !== 8'h0F || bus.alu_b !== 8'hF0) begin
      n_err++; $display("FAIL and_issue: op=%b a=%h b=%h want 00000 0f f0", bus.alu_op, bus.alu_a, bus.alu_b);
    end
    dbg_sel = 2'd0; #1;
    n_cmp++;
    if (dbg_data !== 8'h00) begin n_err++; $display("FAIL and_rf0: got %h want 00", dbg_data); end
  endtask

  task automatic test_wrap;
    int w;
    do_load(2'd2, 8'hFF);
    do_load(2'd3, 8'h01);
    issue(9'b0_0100_10_11, 1'b0, w);
    dbg_sel = 2'd2; #1;
    n_cmp++;
    if (dbg_data !== 8'h00) begin n_err++; $display("FAIL add_wrap: got %h want 00", dbg_data); end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    n_cmp++;
    if (zero_flag !== 1'b1) begin n_err++; $display("FAIL add_zero_flag: got %b want 1", zero_flag); end
`endif
    issue(9'b0_0101_10_11, 1'b0, w);
    dbg_sel = 2'd2; #1;
    n_cmp++;
    if (dbg_data !== 8'hFF) begin n_err++; $display("FAIL sub_wrap: got %h want ff", dbg_data); end
    issue(9'b0_0010_10_00, 1'b0, w);
    dbg_sel = 2'd2; #1;
    n_cmp++;
    if (dbg_data !== 8'h00) begin n_err++; $display("FAIL not_nonzero: got %h want 00", dbg_data); end
    issue(9'b0_0010_10_00, 1'b0, w);
    dbg_sel = 2'd2; #1;
    n_cmp++;
    if (dbg_data !== 8'h01) begin n_err++; $display("FAIL not_zero: got %h want 01", dbg_data); end
  endtask

  task automatic test_shift;
    int w;
    do_load(2'd1, 8'h81);
    issue(9'b1_1_011_01_00, 1'b0, w);
    n_cmp++;
    if (bus.alu_op !== 5'b10001 || bus.alu_b !== 8'h03) begin
      n_err++; $display("FAIL shr_issue: op=%b b=%h want 10001 03", bus.alu_op, bus.alu_b);
    end
    dbg_sel = 2'd1; #1;
    n_cmp++;
    if (dbg_data !== 8'h10) begin n_err++; $display("FAIL shr_rf1: got %h want 10", dbg_data); end
    issue(9'b1_0_010_01_11, 1'b0, w);
    dbg_sel = 2'd1; #1;
    n_cmp++;
    if (dbg_data !== 8'h40) begin n_err++; $display("FAIL shl_rf1: got %h want 40", dbg_data); end
  endtask

  task automatic test_rd_eq_rs;
    int w;
    do_load(2'd3, 8'h40);
    issue(9'b0_0100_11_11, 1'b0, w);
    dbg_sel = 2'd3; #1;
    n_cmp++;
    if (dbg_data !== 8'h80) begin n_err++; $display("FAIL rd_eq_rs_add: got %h want 80", dbg_data); end
  endtask

  task automatic test_illegal;
    int w;
    do_load(2'd0, 8'h55);
    issue(9'b0_0111_00_00, 1'b0, w);
    n_cmp++;
    if (bus.alu_op !== 5'b11111) begin n_err++; $display("FAIL illegal_op: got %b want 11111", bus.alu_op); end
    dbg_sel = 2'd0; #1;
    n_cmp++;
    if (dbg_data !== 8'h55) begin n_err++; $display("FAIL illegal_rf0: got %h want 55", dbg_data); end
  endtask

  task automatic test_load_collision;
    int w;
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 2'd1; load_data = 8'h3C;
    bus.instr = 9'b0_0001_00_01;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.instr_ready !== 1'b0) begin n_err++; $display("FAIL collision_ready: got %b want 0", bus.instr_ready); end
    @(posedge clk); #1;
    load_en = 1'b0;
    sh_rf[1] = 8'h3C;
    issue(9'b0_0001_00_01, 1'b1, w);
    n_cmp++;
    if (w !== 1) begin n_err++; $display("FAIL collision_accept: waited %0d cycles want 1", w); end
  endtask

  task automatic test_back_to_back;
    int         w;
    int         n_done;
    logic [8:0] ins;
    logic [1:0] rd;
    logic [1:0] rs;
    for (int n = 0; n < 14; n++) begin
      rd = 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) do_load(rs, 8'($urandom));
      case ($urandom_range(0, 7))
        6:       ins = {1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), rd, 2'b00};
        7:       ins = {1'b0, 4'($urandom_range(6, 15)), rd, rs};
        default: ins = {1'b0, 4'($urandom_range(0, 5)), rd, rs};
      endcase
      issue(ins, 1'b0, w);
    end
    // Hold valid continuously: one retirement every four cycles.
    @(posedge clk); #1;
    bus.instr = 9'b0_0001_10_00;
    bus.instr_valid = 1'b1;
    n_done = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    sh_rf[2] = sh_rf[2] | sh_rf[0];
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    sh_zf = (sh_rf[2] == 8'h00);
`endif
    n_cmp++;
    if (n_done !== 4) begin n_err++; $display("FAIL throughput: got %0d done pulses in 16 cycles want 4", n_done); end
    repeat (2) @(negedge clk);
    dbg_sel = 2'd2; #1;
    n_cmp++;
    if (dbg_data !== sh_rf[2]) begin n_err++; $display("FAIL b2b_rf2: got %h want %h", dbg_data, sh_rf[2]); end
  endtask

  task automatic test_reset_mid;
    do_load(2'd0, 8'h00);
    do_load(2'd1, 8'h01);
    @(posedge clk); #1;
    bus.instr = 9'b0_0101_00_01;
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) sh_rf[i] = 8'h00;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    sh_zf = 1'b0;
`endif
    #1;
    n_cmp++;
    if (bus.alu_a !== 8'h00 || bus.alu_b !== 8'h00 || bus.alu_op !== 5'b00000) begin
      n_err++; $display("FAIL midreset_alu_bus: a=%h b=%h op=%b want 00 00 00000", bus.alu_a, bus.alu_b, bus.alu_op);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i); #1;
      n_cmp++;
      if (dbg_data !== 8'h00) begin n_err++; $display("FAIL midreset_rf%0d: got %h want 00", i, dbg_data); end
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.instr_ready !== 1'b1) begin n_err++; $display("FAIL midreset_ready: got %b want 1", bus.instr_ready); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (done !== 1'b0) begin n_err++; $display("FAIL midreset_done cycle %0d: got %b want 0", k, done); end
      @(negedge clk);
    end
    dbg_sel = 2'd1; #1;
    n_cmp++;
    if (dbg_data !== 8'h00) begin n_err++; $display("FAIL midreset_no_wb: got %h want 00", dbg_data); end
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    n_cmp++;
    if (zero_flag !== 1'b0) begin n_err++; $display("FAIL midreset_zero_flag: got %b want 0", zero_flag); end
`endif
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    load_en         = 1'b0;
    load_addr       = '0;
    load_data       = '0;
    dbg_sel         = '0;
    for (int i = 0; i < 4; i++) sh_rf[i] = 8'h00;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    sh_zf = 1'b0;
`endif
    test_reset();
    test_and();
    test_wrap();
    test_shift();
    test_rd_eq_rs();
    test_illegal();
    test_load_collision();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/decode controller that drives the 8-bit ALU: it is the initiator side of the ALU operand/opcode interface.
- Accepts a 9-bit instruction over a valid/ready handshake and decodes it to the 5-bit ALU operation code.
- Reads operands from an internal 4x8 register file, presents them to the external combinational ALU, captures the result and writes it back.
- Sits between the instruction front end and the ALU datapath.

Parameters:
- NREG, 4, number of 8-bit registers; fixed at 4 because instruction register fields are 2 bits.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  instruction offered
- instr  in  9  instruction word
- instr_ready  out  1  controller can accept an instruction
- load_en  in  1  register-file direct write strobe
- load_addr  in  2  direct-write register index
- load_data  in  8  direct-write data
- alu_a  out  8  ALU operand in1
- alu_b  out  8  ALU operand in2
- alu_op  out  5  ALU operation code
- alu_result  in  8  ALU combinational output
- done  out  1  one-cycle pulse: instruction retired
- illegal  out  1  one-cycle pulse with done: undefined opcode, no writeback
- dbg_sel  in  2  register-file read select
- dbg_data  out  8  rf[dbg_sel], combinational

Behaviour:
- Instruction format:
  - instr[8]=0 (C-type): instr[7:4]=op, instr[3:2]=rd, instr[1:0]=rs; computes rd = rd OP rs.
  - instr[8]=1 (S-type): instr[7]=dir (0 left, 1 right), instr[6:4]=shamt, instr[3:2]=rd, instr[1:0] ignored.
- Opcode map:
  - C-type: op 0000 AND->00000, 0001 OR->00001, 0010 NOT->00010, 0011 XOR->00011, 0100 ADD->00100, 0101 SUB->00101.
  - op 0110..1111 is illegal: alu_op=11111.
  - S-type: dir=0 -> alu_op=10000; dir=1 -> alu_op=10001.
- Operands:
  - alu_a = rf[rd].
  - alu_b = rf[rs] for C-type; 8'h00 for NOT; {5'b0,shamt} for S-type.
- FSM: IDLE -> DECODE -> EXEC -> WB -> IDLE.
  - IDLE: instr_ready = !load_en. A handshake (instr_valid && instr_ready) at edge T latches instr and moves to DECODE.
  - DECODE: register alu_a, alu_b and alu_op; go to EXEC. These registered outputs are stable from T+2 until the next DECODE.
  - EXEC: capture alu_result into the result register; go to WB.
  - WB: done=1. If legal, rf[rd] <= result. If illegal, illegal=1, rf unchanged, error flag not retained. Go to IDLE.
- Latency and throughput:
  - Handshake at edge T gives done high in cycle T+3.
  - instr_ready is low in DECODE, EXEC and WB, and high again in the cycle after WB.
  - Throughput is one instruction per 4 cycles.
- Arithmetic: all results are 8-bit wrap-around, produced by the ALU; the controller does no arithmetic.
  - ADD 0xFF+0x01 = 0x00.
  - SUB 0x00-0x01 = 0xFF.
  - NOT is the ALU's logical not (0x00->0x01, nonzero->0x00), written back unmodified.
- Direct load:
  - load_en in IDLE writes rf[load_addr] <= load_data at the edge.
  - load_en outside IDLE is ignored.
  - load_en together with instr_valid in IDLE: the load wins and the instruction is not accepted (instr_ready=0 that cycle).
- rd == rs is legal: both operands read the same pre-instruction value.
- instr_valid deasserting while instr_ready=0 has no effect; instr is sampled only at the handshake.
- Reset (rst_n=0, asynchronous):
  - state=IDLE; rf all 0x00; alu_a=alu_b=0x00; alu_op=00000; done=0; illegal=0; result=0x00.
  - Reset mid-instruction aborts it with no writeback and no done.
  - instr_ready=1 in the first cycle after release.

Optional Feature:
- Macro: ALU_ISSUE_ZERO_FLAG_EN.
- When defined:
  - Adds output port zero_flag (1 bit), reset 0.
  - In WB of a legal instruction, zero_flag <= (result == 0x00).
  - Illegal instructions leave zero_flag unchanged; load_en does not affect it.
- When undefined: the port and register are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, then load rf0=0x0F, rf1=0xF0; issue AND (instr=0_0000_00_01) -> DECODE cycle drives alu_op=00000, alu_a=0x0F, alu_b=0xF0; done at T+3; dbg rf0=0x00.
- rf2=0xFF, rf3=0x01; issue ADD rd=2, rs=3 -> rf2=0x00 (wrap); with ALU_ISSUE_ZERO_FLAG_EN, zero_flag=1.
- rf1=0x81; issue S-type right shift, shamt=3, rd=1 (instr=1_1_011_01_00) -> alu_op=10001, alu_b=0x03, rf1=0x10.
- Issue illegal op 0111 with rd=0 holding 0x55 -> alu_op=11111; done and illegal both pulse; rf0 stays 0x55.
- Assert load_en and instr_valid together in IDLE -> load written, instr_ready=0, instruction accepted the next cycle with done 3 cycles after that.
- Assert rst_n=0 during EXEC of SUB -> no done pulse; all rf=0x00; instr_ready=1 in the first cycle after release.
